// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART receiver frame controller: state encoding,
// parity sense and the legal oversampling ratios.
package uart_rx_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_START      = 3'd1;
    localparam logic [2:0] ST_DATA       = 3'd2;
    localparam logic [2:0] ST_PARITY     = 3'd3;
    localparam logic [2:0] ST_STOP       = 3'd4;
    localparam logic [2:0] ST_BREAK_WAIT = 3'd5;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    // Index of the last edge in a bit; unsupported ratios fall back to 8.
    function automatic logic [4:0] last_edge_of(input logic [31:0] prescale);
        logic [4:0] last;
        last = 5'(PRESCALE_8 - 1);
        if (prescale == 32'(PRESCALE_16))
            last = 5'(PRESCALE_16 - 1);
        else if (prescale == 32'(PRESCALE_32))
            last = 5'(PRESCALE_32 - 1);
        return last;
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Per-bit edge counter with bit-end strobe, plus the data bit counter.
// Both are controlled by the frame FSM through enable/clear inputs.
module uart_rx_edge_bit_cnt #(
    parameter int BIT_W = 3
) (
    input  logic             data_sampling_clk,
    input  logic             data_sampling_rst,
    input  logic             cnt_en,
    input  logic [4:0]       last_edge,
    input  logic             bit_clr,
    input  logic             bit_inc,
    output logic [4:0]       edge_cnt,
    output logic             bit_end,
    output logic [BIT_W-1:0] bit_cnt
);

    assign bit_end = cnt_en && (edge_cnt == last_edge);

    // The edge counter sits at 0 whenever the FSM is not timing a bit.
    always_ff @(posedge data_sampling_clk or negedge data_sampling_rst) begin
        if (!data_sampling_rst)
            edge_cnt <= 5'd0;
        else if (!cnt_en || bit_end)
            edge_cnt <= 5'd0;
        else
            edge_cnt <= edge_cnt + 5'd1;
    end

    always_ff @(posedge data_sampling_clk or negedge data_sampling_rst) begin
        if (!data_sampling_rst)
            bit_cnt <= '0;
        else if (bit_clr)
            bit_cnt <= '0;
        else if (bit_inc && bit_end)
            bit_cnt <= bit_cnt + BIT_W'(1);
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver frame-sequencing FSM: start detect, LSB-first deserialise,
// parity/stop checks. Optional break detection under UART_RX_BREAK_DET_EN.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  data_sampling_clk,
    input  logic                  data_sampling_rst,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_bit,
    output logic                  dat_samp_en,
    output logic [4:0]            edge_cnt,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
`ifdef UART_RX_BREAK_DET_EN
    output logic                  break_det,
`endif
    output logic                  strt_glitch
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic [4:0]            last_edge_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_flag;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  bit_end;
    logic                  cnt_en;
    logic                  leave_idle;
    logic                  stop_end;
    logic                  last_data_bit;
    logic                  par_expected;
    logic                  break_cond;

    assign leave_idle    = (state == ST_IDLE) && !RX_IN;
    assign cnt_en        = (state == ST_START) || (state == ST_DATA) ||
                           (state == ST_PARITY) || (state == ST_STOP);
    assign last_data_bit = (bit_cnt == BIT_W'(DATA_WIDTH - 1));
    assign par_expected  = (^shift_q) ^ (par_typ_q == PAR_ODD);
    assign stop_end      = (state == ST_STOP) && bit_end;
    assign break_cond    = stop_end && !sampled_bit && (shift_q == '0);

    uart_rx_edge_bit_cnt #(
        .BIT_W (BIT_W)
    ) u_edge_bit_cnt (
        .data_sampling_clk (data_sampling_clk),
        .data_sampling_rst (data_sampling_rst),
        .cnt_en            (cnt_en),
        .last_edge         (last_edge_q),
        .bit_clr           (state == ST_START),
        .bit_inc           (state == ST_DATA),
        .edge_cnt          (edge_cnt),
        .bit_end           (bit_end),
        .bit_cnt           (bit_cnt)
    );

    // Pulses are decoded from registered state and the registered sampled_bit.
    assign dat_samp_en = cnt_en;
    assign strt_glitch = (state == ST_START) && bit_end && sampled_bit;
    assign data_valid  = stop_end && sampled_bit && !par_flag;
    assign par_err     = stop_end && sampled_bit && par_flag;
`ifdef UART_RX_BREAK_DET_EN
    assign break_det   = break_cond;
    assign stp_err     = stop_end && !sampled_bit && !break_cond;
`else
    assign stp_err     = stop_end && !sampled_bit;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (!RX_IN) state_nxt = ST_START;
            ST_START:  if (bit_end) state_nxt = sampled_bit ? ST_IDLE : ST_DATA;
            ST_DATA:   if (bit_end && last_data_bit) state_nxt = par_en_q ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_end) state_nxt = ST_STOP;
`ifdef UART_RX_BREAK_DET_EN
            ST_STOP:   if (bit_end) state_nxt = break_cond ? ST_BREAK_WAIT : ST_IDLE;
            ST_BREAK_WAIT: if (RX_IN) state_nxt = ST_IDLE;
`else
            ST_STOP:   if (bit_end) state_nxt = ST_IDLE;
`endif
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge data_sampling_clk or negedge data_sampling_rst) begin
        if (!data_sampling_rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Frame configuration is frozen for the whole frame once the start edge is seen.
    always_ff @(posedge data_sampling_clk or negedge data_sampling_rst) begin
        if (!data_sampling_rst) begin
            last_edge_q <= 5'd7;
            par_en_q    <= 1'b0;
            par_typ_q   <= 1'b0;
        end else if (leave_idle) begin
            last_edge_q <= last_edge_of(32'(Prescale));
            par_en_q    <= PAR_EN;
            par_typ_q   <= PAR_TYP;
        end
    end

    always_ff @(posedge data_sampling_clk or negedge data_sampling_rst) begin
        if (!data_sampling_rst)
            shift_q <= '0;
        else if ((state == ST_DATA) && bit_end)
            shift_q[bit_cnt] <= sampled_bit;
    end

    always_ff @(posedge data_sampling_clk or negedge data_sampling_rst) begin
        if (!data_sampling_rst)
            par_flag <= 1'b0;
        else if (leave_idle)
            par_flag <= 1'b0;
        else if ((state == ST_PARITY) && bit_end && (sampled_bit != par_expected))
            par_flag <= 1'b1;
    end

    // The visible byte only changes on a good frame; error frames keep the old one.
    always_ff @(posedge data_sampling_clk or negedge data_sampling_rst) begin
        if (!data_sampling_rst)
            P_DATA <= '0;
        else if (data_valid)
            P_DATA <= shift_q;
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed frames followed by random
// frames, compared cycle by cycle against a bit-window reference model.
module tb_uart_rx_ctrl;

    logic       data_sampling_clk;
    logic       data_sampling_rst;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       sampled_bit;
    logic       dat_samp_en;
    logic [4:0] edge_cnt;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       strt_glitch;
`ifdef UART_RX_BREAK_DET_EN
    logic       break_det;
`endif

    int         total;
    int         bad;
    logic [7:0] model_pdata;
    bit         last_break;

    uart_rx_ctrl #(
        .DATA_WIDTH (8),
        .PRESCALE_W (6)
    ) dut (
        .data_sampling_clk (data_sampling_clk),
        .data_sampling_rst (data_sampling_rst),
        .RX_IN             (RX_IN),
        .Prescale          (Prescale),
        .PAR_EN            (PAR_EN),
        .PAR_TYP           (PAR_TYP),
        .sampled_bit       (sampled_bit),
        .dat_samp_en       (dat_samp_en),
        .edge_cnt          (edge_cnt),
        .P_DATA            (P_DATA),
        .data_valid        (data_valid),
        .par_err           (par_err),
        .stp_err           (stp_err),
`ifdef UART_RX_BREAK_DET_EN
        .break_det         (break_det),
`endif
        .strt_glitch       (strt_glitch)
    );

    initial data_sampling_clk = 1'b0;
    always #5 data_sampling_clk = ~data_sampling_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            if (bad <= 40)
                $display("[TB] FAIL %s at %0t: got %0h want %0h", tag, $time, observed, expected);
        end
    endtask

    task automatic checkQuiet(input string tag, input bit exp_en, input int exp_edge);
        checkOutput({tag, ".en"}, 32'(dat_samp_en), 32'(exp_en));
        checkOutput({tag, ".edge"}, 32'(edge_cnt), 32'(exp_edge));
        checkOutput({tag, ".pdata"}, 32'(P_DATA), 32'(model_pdata));
    endtask

    task automatic checkPulses(input string tag, input bit dv, input bit pe, input bit se, input bit sg, input bit bd);
        checkOutput({tag, ".data_valid"}, 32'(data_valid), 32'(dv));
        checkOutput({tag, ".par_err"}, 32'(par_err), 32'(pe));
        checkOutput({tag, ".stp_err"}, 32'(stp_err), 32'(se));
        checkOutput({tag, ".strt_glitch"}, 32'(strt_glitch), 32'(sg));
`ifdef UART_RX_BREAK_DET_EN
        checkOutput({tag, ".break_det"}, 32'(break_det), 32'(bd));
`else
        if (bd) checkOutput({tag, ".break_unexpected"}, 32'(stp_err), 32'(1));
`endif
    endtask

    task automatic idleCycles(input int n, input logic rx);
        for (int k = 0; k < n; k++) begin
            @(negedge data_sampling_clk);
            RX_IN = rx;
            sampled_bit = 1'($urandom);
            #1;
            checkQuiet("idle", 1'b0, 0);
            checkPulses("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // One frame, starting with the IDLE cycle that sees the falling edge.
    // The line carries bit k in window [kP, kP+P) and sampled_bit lags it by one
    // cycle, which lines each bit up with the controller's bit-end edge.
    task automatic applyStimulus(input int pcfg, input bit pen, input bit ptyp,
                                 input logic [7:0] data, input bit par_ok,
                                 input bit stop_bit, input int abort_at);
        bit bits[$];
        int p;
        int n;
        bit par_bad;
        bit brk;
        bit last;
        p = (pcfg == 16 || pcfg == 32) ? pcfg : 8;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(data[i]);
        if (pen) bits.push_back((^data) ^ ptyp ^ !par_ok);
        bits.push_back(stop_bit);
        n = bits.size();
        par_bad = pen && !par_ok;
        brk = !stop_bit && (data == 8'h00);
        last_break = 1'b0;
        for (int j = 0; j <= n * p; j++) begin
            @(negedge data_sampling_clk);
            if (j == 0) begin
                Prescale = 6'(pcfg);
                PAR_EN   = pen;
                PAR_TYP  = ptyp;
            end else if ($urandom_range(0, 3) == 0) begin
                Prescale = 6'($urandom);
                PAR_EN   = 1'($urandom);
                PAR_TYP  = 1'($urandom);
            end
            RX_IN = (j < n * p) ? bits[j / p] : 1'b1;
            sampled_bit = (j >= 1) ? bits[(j - 1) / p] : 1'($urandom);
            if (j == abort_at) begin
                data_sampling_rst = 1'b0;
                model_pdata = 8'h00;
                #1;
                checkQuiet("reset", 1'b0, 0);
                checkPulses("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                @(negedge data_sampling_clk);
                RX_IN = 1'b1;
                data_sampling_rst = 1'b1;
                return;
            end
            #1;
            last = (j == n * p);
            checkQuiet("frame", j >= 1, (j >= 1) ? (j - 1) % p : 0);
`ifdef UART_RX_BREAK_DET_EN
            checkPulses("frame", last && stop_bit && !par_bad, last && stop_bit && par_bad,
                        last && !stop_bit && !brk, 1'b0, last && brk);
`else
            checkPulses("frame", last && stop_bit && !par_bad, last && stop_bit && par_bad,
                        last && !stop_bit, 1'b0, 1'b0);
`endif
        end
        if (stop_bit && !par_bad) model_pdata = data;
`ifdef UART_RX_BREAK_DET_EN
        last_break = brk;
`endif
    endtask

    // Start edge that is gone by mid-bit: the majority reads 1 at START end.
    task automatic applyGlitch(input int pcfg, input int low_cycles);
        int p;
        p = (pcfg == 16 || pcfg == 32) ? pcfg : 8;
        for (int j = 0; j <= p; j++) begin
            @(negedge data_sampling_clk);
            if (j == 0) Prescale = 6'(pcfg);
            RX_IN = (j < low_cycles) ? 1'b0 : 1'b1;
            sampled_bit = 1'b1;
            #1;
            checkQuiet("glitch", j >= 1, (j >= 1) ? j - 1 : 0);
            checkPulses("glitch", 1'b0, 1'b0, 1'b0, j == p, 1'b0);
        end
    endtask

    initial begin
        int pset[4];
        total = 0;
        bad = 0;
        model_pdata = 8'h00;
        last_break = 1'b0;
        RX_IN = 1'b1;
        Prescale = 6'd8;
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
        sampled_bit = 1'b1;
        data_sampling_rst = 1'b0;
        pset[0] = 8; pset[1] = 16; pset[2] = 32; pset[3] = 12;

        #12;
        checkQuiet("por", 1'b0, 0);
        checkPulses("por", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge data_sampling_clk);
        data_sampling_rst = 1'b1;
        idleCycles(3, 1'b1);

        applyStimulus(8, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, -1);
        applyStimulus(16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, -1);
        applyStimulus(16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, -1);
        applyStimulus(32, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0, -1);
        applyStimulus(32, 1'b0, 1'b0, 8'h0F, 1'b1, 1'b1, -1);
        applyStimulus(16, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, -1);
        idleCycles(2, 1'b1);
        applyGlitch(8, 2);
        idleCycles(1, 1'b1);
        applyStimulus(16, 1'b0, 1'b0, 8'h77, 1'b1, 1'b1, 16 * 4 + 3);
        idleCycles(2, 1'b1);
        applyStimulus(16, 1'b0, 1'b0, 8'h81, 1'b1, 1'b1, -1);
        applyStimulus(8, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, -1);
        if (last_break) begin
            idleCycles(8 * 3, 1'b0);
            idleCycles(1, 1'b1);
        end
        idleCycles(1, 1'b1);

        for (int f = 0; f < 40; f++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                applyGlitch(pset[$urandom_range(0, 3)], $urandom_range(1, 3));
            end else begin
                applyStimulus(pset[$urandom_range(0, 3)], 1'($urandom), 1'($urandom),
                              (r == 1) ? 8'h00 : 8'($urandom),
                              $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, -1);
                if (last_break) begin
                    idleCycles($urandom_range(1, 20), 1'b0);
                    idleCycles(1, 1'b1);
                end
            end
            if ($urandom_range(0, 1) == 1) idleCycles($urandom_range(1, 3), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Frame-sequencing FSM for the UART receiver.
- Detects the start edge on RX_IN and runs the per-bit edge counter that drives data_sampling.
- Gates dat_samp_en, consumes sampled_bit, deserialises data LSB-first, and checks start, parity and stop bits.
- Emits data_valid and error pulses to the receiver top level.

Parameters:
DATA_WIDTH, 8, data bits per frame
PRESCALE_W, 6, width of Prescale input (must hold 32)

Ports:
data_sampling_clk  input  1  oversampling clock
data_sampling_rst  input  1  asynchronous active-low reset
RX_IN  input  1  serial line, idle high
Prescale  input  PRESCALE_W  oversampling ratio; 8, 16 or 32 legal, any other value treated as 8
PAR_EN  input  1  parity bit present
PAR_TYP  input  1  0 = even, 1 = odd
sampled_bit  input  1  majority bit from data_sampling
dat_samp_en  output  1  enable to data_sampling
edge_cnt  output  5  edge index within current bit, to data_sampling
P_DATA  output  DATA_WIDTH  received byte, held until next valid frame
data_valid  output  1  one-cycle pulse, frame good
par_err  output  1  one-cycle pulse, parity mismatch
stp_err  output  1  one-cycle pulse, stop bit sampled 0
strt_glitch  output  1  one-cycle pulse, start bit rejected

Behaviour:
- Reset: data_sampling_clk / data_sampling_rst, asynchronous, active-low.
  - While reset is asserted: state IDLE, edge_cnt=0, bit_cnt=0, all outputs 0, P_DATA=0.
  - Reset mid-frame aborts the frame. No pulse is emitted.
- Per-frame latch: Prescale, PAR_EN and PAR_TYP are latched when leaving IDLE. Changes mid-frame are ignored.
- Bit timing: P = latched prescale.
  - edge_cnt counts 0..P-1 and wraps to 0 when it ends a bit.
  - edge_cnt is held 0 in IDLE.
- Sampling: dat_samp_en=1 in every state except IDLE.
  - sampled_bit is consumed only at edge_cnt==P-1 ("bit end").
  - data_sampling captures at P/2-1, P/2, P/2+1 and registers the majority by P/2+3 <= P-1. This holds for all legal P.
- State machine (IDLE, START, DATA, PARITY, STOP):
  - IDLE: RX_IN==0 moves to START, with edge_cnt=0 in the next cycle.
  - START, at bit end:
    - sampled_bit==0 -> DATA, bit_cnt=0.
    - Otherwise strt_glitch pulses and the FSM returns to IDLE.
  - DATA, at bit end: P_DATA shift register captures sampled_bit into bit position bit_cnt (LSB first), then bit_cnt+1.
    - After bit DATA_WIDTH-1: -> PARITY if PAR_EN, else -> STOP.
  - PARITY, at bit end: expected = XOR(data bits) XOR PAR_TYP. A mismatch sets the internal par_flag. Then -> STOP.
  - STOP, at bit end: -> IDLE, and exactly one of the following in the same cycle:
    - sampled_bit==0: stp_err pulses.
    - else par_flag set: par_err pulses.
    - else: data_valid pulses.
- P_DATA: the output register updates only on the data_valid cycle. On error frames P_DATA keeps the previous good byte.
- Back-to-back frames: after STOP the FSM spends one cycle in IDLE, then detects the next start edge (<= 1/8 bit skew).
- Line low at STOP exit: re-enters START. A false start is rejected by the START check.
- Error priority: stp_err > par_err. At most one pulse per frame.

Optional Feature:
- Macro: UART_RX_BREAK_DET_EN.
- Defined:
  - Adds output port break_det (1 bit) and state BREAK_WAIT.
  - Break condition: stop bit sampled 0 with all data bits 0. On it, break_det pulses one cycle instead of stp_err, and the FSM enters BREAK_WAIT.
  - BREAK_WAIT holds until RX_IN==1, then -> IDLE. dat_samp_en=0 in BREAK_WAIT.
- Undefined: no port, no state. Break reports as stp_err and the FSM returns to IDLE directly.

Decomposition:
- Package uart_rx_pkg:
  - State encoding localparams (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, BREAK_WAIT=5).
  - PAR_EVEN/PAR_ODD constants.
  - Legal-prescale constants.
- Sub-module uart_rx_edge_bit_cnt: edge counter with bit-end strobe plus bit counter, with enable and clear from the FSM.

Test Plan:
- P=8, PAR_EN=0, send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> data_valid pulse at 80th edge, P_DATA=0xA5, no errors.
- P=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity 0 -> data_valid, P_DATA=0x3C; repeat with parity 1 -> par_err pulse, P_DATA stays 0x3C.
- P=32, 0x55 with stop bit 0 -> stp_err only, no data_valid. Then a good 0x0F frame back-to-back -> data_valid, P_DATA=0x0F.
- P=8, RX_IN low for 2 clocks then high -> strt_glitch pulse at edge_cnt==7, back to IDLE, dat_samp_en=0.
- Assert data_sampling_rst mid-DATA at P=16 -> outputs 0 immediately. Next full 0x81 frame -> data_valid, P_DATA=0x81.
- UART_RX_BREAK_DET_EN defined, RX_IN held low 12 bit-times -> break_det pulse, FSM holds in BREAK_WAIT until RX_IN=1, no stp_err.
